// File: rtl/hazard_scoreboard.sv
// Destination-tag pipeline (ID/EX .. post-WB) and stall generator for load-use
// and ecall/x17 hazards that forwarding cannot resolve.
module hazard_scoreboard #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_is_ecall,
    input  logic             flush,
    output logic             stall,
    output logic [4:0]       ID_EX_rd,
    output logic             ID_EX_reg_write,
    output logic             ID_EX_mem_read,
    output logic [4:0]       EX_MEM_rd,
    output logic             EX_MEM_reg_write,
    output logic             EX_MEM_mem_read,
    output logic [4:0]       MEM_WB_rd,
    output logic             MEM_WB_reg_write,
    output logic [4:0]       WB_write_rd,
    output logic             WB_reg_write,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam logic [4:0] X17 = 5'd17;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
    } ld_tag_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       reg_write;
    } wr_tag_t;

    ld_tag_t          id_ex_q, id_ex_d, ex_mem_q;
    wr_tag_t          mem_wb_q, wb_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             id_ex_eff, ex_mem_eff, load_use, ecall_hz;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        id_ex_eff  = id_ex_q.reg_write && (id_ex_q.rd != 5'd0);
        ex_mem_eff = ex_mem_q.reg_write && (ex_mem_q.rd != 5'd0);

        load_use = id_valid && id_ex_eff && id_ex_q.mem_read &&
                   ((id_use_rs1 && (id_rs1 == id_ex_q.rd)) ||
                    (id_use_rs2 && (id_rs2 == id_ex_q.rd)));

        ecall_hz = id_valid && id_is_ecall &&
                   ((id_ex_eff && (id_ex_q.rd == X17)) ||
                    (ex_mem_eff && (ex_mem_q.rd == X17) && ex_mem_q.mem_read));

        stall = (load_use || ecall_hz) && !flush && !reset;

        // Flush, stall and an empty ID slot all inject the same bubble.
        id_ex_d = '0;
        if (id_valid && !flush && !stall) begin
            id_ex_d = '{rd: id_rd, reg_write: id_reg_write, mem_read: id_mem_read};
        end

        cnt_d = cnt_q;
        if (stall && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            id_ex_q  <= '0;
            ex_mem_q <= '0;
            mem_wb_q <= '0;
            wb_q     <= '0;
            cnt_q    <= '0;
        end else begin
            id_ex_q  <= id_ex_d;
            ex_mem_q <= id_ex_q;
            mem_wb_q <= '{rd: ex_mem_q.rd, reg_write: ex_mem_q.reg_write};
            wb_q     <= mem_wb_q;
            cnt_q    <= cnt_d;
        end
    end

    assign ID_EX_rd         = id_ex_q.rd;
    assign ID_EX_reg_write  = id_ex_q.reg_write;
    assign ID_EX_mem_read   = id_ex_q.mem_read;
    assign EX_MEM_rd        = ex_mem_q.rd;
    assign EX_MEM_reg_write = ex_mem_q.reg_write;
    assign EX_MEM_mem_read  = ex_mem_q.mem_read;
    assign MEM_WB_rd        = mem_wb_q.rd;
    assign MEM_WB_reg_write = mem_wb_q.reg_write;
    assign WB_write_rd      = wb_q.rd;
    assign WB_reg_write     = wb_q.reg_write;
    assign stall_cycles     = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: an issue-history model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_hazard_scoreboard;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
        logic       mr;
    } tag_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             id_valid = 1'b0;
    logic [4:0]       id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic             id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic             id_reg_write = 1'b0, id_mem_read = 1'b0;
    logic             id_is_ecall = 1'b0, flush = 1'b0;
    logic             stall;
    logic [4:0]       ID_EX_rd, EX_MEM_rd, MEM_WB_rd, WB_write_rd;
    logic             ID_EX_reg_write, ID_EX_mem_read, EX_MEM_reg_write, EX_MEM_mem_read;
    logic             MEM_WB_reg_write, WB_reg_write;
    logic [CNT_W-1:0] stall_cycles;

    int cmp_cnt = 0;
    int err_cnt = 0;
    bit done = 1'b0;

    hazard_scoreboard #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_is_ecall(id_is_ecall), .flush(flush), .stall(stall),
        .ID_EX_rd(ID_EX_rd), .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_mem_read(ID_EX_mem_read),
        .EX_MEM_rd(EX_MEM_rd), .EX_MEM_reg_write(EX_MEM_reg_write), .EX_MEM_mem_read(EX_MEM_mem_read),
        .MEM_WB_rd(MEM_WB_rd), .MEM_WB_reg_write(MEM_WB_reg_write),
        .WB_write_rd(WB_write_rd), .WB_reg_write(WB_reg_write), .stall_cycles(stall_cycles)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: list of tags that entered ID/EX, newest first; stage k is entry k.
    tag_t hist[$];
    int   m_cnt = 0;

    function automatic tag_t stage_tag(input int k);
        return (k < hist.size()) ? hist[k] : tag_t'('0);
    endfunction

    function automatic logic m_stall();
        tag_t ie = stage_tag(0);
        tag_t em = stage_tag(1);
        logic lu, ec;
        if (reset) return 1'b0;
        lu = id_valid && ie.rw && ie.rd != 0 && ie.mr &&
             ((id_use_rs1 && id_rs1 == ie.rd) || (id_use_rs2 && id_rs2 == ie.rd));
        ec = id_valid && id_is_ecall &&
             ((ie.rw && ie.rd != 0 && ie.rd == 5'd17) ||
              (em.rw && em.rd != 0 && em.rd == 5'd17 && em.mr));
        return (lu || ec) && !flush;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            hist.delete();
            m_cnt = 0;
        end else begin
            logic s;
            tag_t nt;
            s  = m_stall();
            nt = (s || flush || !id_valid) ? tag_t'('0) : tag_t'({id_rd, id_reg_write, id_mem_read});
            hist.push_front(nt);
            if (hist.size() > 4) void'(hist.pop_back());
            if (s && m_cnt < (2 ** CNT_W) - 1) m_cnt++;
        end
    end

    always @(negedge clk) begin
        if (!done) begin
            tag_t t0, t1, t2, t3;
            t0 = stage_tag(0); t1 = stage_tag(1); t2 = stage_tag(2); t3 = stage_tag(3);
            check("m_stall", 32'(stall), 32'(m_stall()));
            check("m_id_ex_rd", 32'(ID_EX_rd), 32'(t0.rd));
            check("m_id_ex_rw", 32'(ID_EX_reg_write), 32'(t0.rw));
            check("m_id_ex_mr", 32'(ID_EX_mem_read), 32'(t0.mr));
            check("m_ex_mem_rd", 32'(EX_MEM_rd), 32'(t1.rd));
            check("m_ex_mem_rw", 32'(EX_MEM_reg_write), 32'(t1.rw));
            check("m_ex_mem_mr", 32'(EX_MEM_mem_read), 32'(t1.mr));
            check("m_mem_wb_rd", 32'(MEM_WB_rd), 32'(t2.rd));
            check("m_mem_wb_rw", 32'(MEM_WB_reg_write), 32'(t2.rw));
            check("m_wb_rd", 32'(WB_write_rd), 32'(t3.rd));
            check("m_wb_rw", 32'(WB_reg_write), 32'(t3.rw));
            check("m_stall_cycles", 32'(stall_cycles), 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_id(input logic v, input logic [4:0] rd, input logic rw, input logic mr,
                          input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic ec);
        id_valid = v; id_rd = rd; id_reg_write = rw; id_mem_read = mr;
        id_rs1 = rs1; id_use_rs1 = u1; id_rs2 = rs2; id_use_rs2 = u2; id_is_ecall = ec;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        tick();
        nop();
        flush = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        #1;
        check("por_stall", 32'(stall), 0);
        check("por_id_ex_rd", 32'(ID_EX_rd), 0);
        check("por_cnt", 32'(stall_cycles), 0);
        reset = 1'b0;

        // Latency: add x5 reaches ID/EX after one edge, WB after four.
        tick();
        set_id(1, 5'd5, 1, 0, 5'd1, 1, 5'd2, 1, 0);
        tick();
        nop();
        #1 check("lat_id_ex_rd", 32'(ID_EX_rd), 5);
        tick(); tick(); tick();
        #1;
        check("lat_wb_rd", 32'(WB_write_rd), 5);
        check("lat_wb_rw", 32'(WB_reg_write), 1);

        // Async reset mid-cycle with tags in every stage.
        for (int i = 1; i <= 4; i++) begin
            set_id(1, 5'(i), 1, 0, 5'd0, 0, 5'd0, 0, 0);
            tick();
        end
        #1;
        check("pre_rst_id_ex", 32'(ID_EX_rd), 4);
        check("pre_rst_wb", 32'(WB_write_rd), 1);
        #1 reset = 1'b1;
        #1;
        check("rst_id_ex_rd", 32'(ID_EX_rd), 0);
        check("rst_ex_mem_rd", 32'(EX_MEM_rd), 0);
        check("rst_mem_wb_rd", 32'(MEM_WB_rd), 0);
        check("rst_wb_rd", 32'(WB_write_rd), 0);
        check("rst_wb_rw", 32'(WB_reg_write), 0);
        check("rst_stall", 32'(stall), 0);
        nop();
        tick();
        reset = 1'b0;

        // Load-use: lw x7 ; add x8, x7, x1.
        set_id(1, 5'd7, 1, 1, 5'd2, 1, 5'd0, 0, 0);
        tick();
        set_id(1, 5'd8, 1, 0, 5'd7, 1, 5'd1, 1, 0);
        #1 check("lu_stall", 32'(stall), 1);
        tick();
        #1;
        check("lu_stall_clear", 32'(stall), 0);
        check("lu_bubble_rw", 32'(ID_EX_reg_write), 0);
        check("lu_ex_mem_mr", 32'(EX_MEM_mem_read), 1);
        check("lu_cnt", 32'(stall_cycles), 1);
        tick();
        nop();
        #1 check("lu_add_issued", 32'(ID_EX_rd), 8);

        // Load to x0: no hazard.
        do_reset();
        set_id(1, 5'd0, 1, 1, 5'd2, 1, 5'd0, 0, 0);
        tick();
        set_id(1, 5'd8, 1, 0, 5'd0, 1, 5'd0, 1, 0);
        #1 check("lu_x0_stall", 32'(stall), 0);
        // rs1 matches but is not read.
        tick();
        set_id(1, 5'd7, 1, 1, 5'd2, 1, 5'd0, 0, 0);
        tick();
        set_id(1, 5'd8, 1, 0, 5'd7, 0, 5'd3, 1, 0);
        #1 check("lu_nouse_stall", 32'(stall), 0);
        tick();
        // rs2 path.
        set_id(1, 5'd7, 1, 1, 5'd2, 1, 5'd0, 0, 0);
        tick();
        set_id(1, 5'd9, 1, 0, 5'd3, 1, 5'd7, 1, 0);
        #1 check("lu_rs2_stall", 32'(stall), 1);
        tick();
        nop();

        // Ecall after ALU write to x17.
        do_reset();
        set_id(1, 5'd17, 1, 0, 5'd0, 1, 5'd0, 0, 0);
        tick();
        set_id(1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1);
        #1 check("ec_alu_stall", 32'(stall), 1);
        tick();
        #1 check("ec_alu_clear", 32'(stall), 0);
        tick();
        nop();
        #1 check("ec_alu_cnt", 32'(stall_cycles), 1);
        do_reset();
        set_id(1, 5'd17, 1, 0, 5'd0, 1, 5'd0, 0, 0);
        tick();
        set_id(1, 5'd9, 1, 0, 5'd1, 1, 5'd2, 1, 0);
        tick();
        set_id(1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1);
        #1 check("ec_alu_d2_stall", 32'(stall), 0);
        tick();
        nop();

        // Ecall after load to x17: two stalls, then one with a gap.
        do_reset();
        set_id(1, 5'd17, 1, 1, 5'd2, 1, 5'd0, 0, 0);
        tick();
        set_id(1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1);
        #1 check("ec_ld_stall1", 32'(stall), 1);
        tick();
        #1 check("ec_ld_stall2", 32'(stall), 1);
        tick();
        #1;
        check("ec_ld_clear", 32'(stall), 0);
        check("ec_ld_cnt", 32'(stall_cycles), 2);
        tick();
        nop();
        do_reset();
        set_id(1, 5'd17, 1, 1, 5'd2, 1, 5'd0, 0, 0);
        tick();
        set_id(1, 5'd9, 1, 0, 5'd1, 1, 5'd2, 1, 0);
        tick();
        set_id(1, 5'd0, 0, 0, 5'd0, 0, 5'd0, 0, 1);
        #1 check("ec_ld_d2_stall", 32'(stall), 1);
        tick();
        #1;
        check("ec_ld_d2_clear", 32'(stall), 0);
        check("ec_ld_d2_cnt", 32'(stall_cycles), 1);
        tick();
        nop();

        // Flush masks a load-use hazard; invalid ID gives a bubble.
        do_reset();
        set_id(1, 5'd7, 1, 1, 5'd2, 1, 5'd0, 0, 0);
        tick();
        set_id(1, 5'd8, 1, 0, 5'd7, 1, 5'd1, 1, 0);
        flush = 1'b1;
        #1 check("fl_stall", 32'(stall), 0);
        tick();
        flush = 1'b0;
        set_id(0, 5'd9, 1, 0, 5'd8, 1, 5'd0, 0, 0);
        #1;
        check("fl_bubble_rd", 32'(ID_EX_rd), 0);
        check("fl_bubble_rw", 32'(ID_EX_reg_write), 0);
        check("fl_cnt", 32'(stall_cycles), 0);
        tick();
        #1 check("inv_bubble_rd", 32'(ID_EX_rd), 0);
        set_id(1, 5'd7, 1, 1, 5'd2, 1, 5'd0, 0, 0);
        tick();
        set_id(0, 5'd8, 1, 0, 5'd7, 1, 5'd1, 1, 0);
        #1 check("inv_no_stall", 32'(stall), 0);
        tick();
        nop();

        // Saturation: dependent loads stall every other cycle.
        do_reset();
        set_id(1, 5'd7, 1, 1, 5'd7, 1, 5'd0, 0, 0);
        for (int i = 0; i < 40; i++) tick();
        nop();
        #1 check("sat_cnt", 32'(stall_cycles), 15);
        tick();
        #1 check("sat_hold", 32'(stall_cycles), 15);

        done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
